pulse_arbiter: RTL
==================

// Module: pulse_arbiter
// PURPOSE
//  Shares one pulse controller (inputs init/per, output pulse) among N requesters.
//  Grants one requester at a time in round-robin order and drives the controller's init and per.
//  Counts the pulses it returns, then releases the controller and signals completion.
//  Sits between the requesting blocks and the single pulse controller.
// PARAMETERS
//  N           4    number of requesters (2..8)
//  INIT_CYCLES 8    cycles ctl_init is held high per grant (>=1)
//  NPULSE      4    pulses served per grant in periodic mode (>=1)
//  TIMEOUT     256  max cycles in WAIT without a new pulse edge before forced release (>=2)
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  req        in   N  request lines; level-sensitive, one bit per requester
//  mode       in   N  per-requester mode; 1 = periodic (per=1), 0 = single pulse
//  ctl_pulse  in   1  pulse output of the shared controller
//  ctl_init   out  1  init to the controller
//  ctl_per    out  1  per to the controller
//  gnt        out  N  one-hot grant, held for the whole service
//  done       out  N  one-cycle strobe on the served requester's bit at release
//  err        out  1  one-cycle strobe when a release is caused by timeout
//  busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; state IDLE; RR pointer=0; counters 0; pulse edge reg 0.
//  Reset mid-service: ctl_init/ctl_per/gnt drop immediately, with no done and no err.
//  Pulse edge: rise = ctl_pulse & ~ctl_pulse_q; ctl_pulse_q is registered every cycle.
//  FSM states: IDLE -> ARM -> WAIT -> RELEASE -> IDLE.
//  IDLE:
//   - If any req bit is set, pick the first set bit scanning ptr, ptr+1, ... mod N.
//   - Latch idx and mode[idx]; go to ARM.
//   - gnt[idx], ctl_init=1 and ctl_per=mode_l take effect at the next edge.
//   - Latency is 1 cycle from req being sampled.
//  ARM:
//   - ctl_init=1 for exactly INIT_CYCLES cycles; ctl_per=mode_l; then go to WAIT.
//   - A req drop during ARM does not shorten ARM; it is acted on in WAIT.
//  WAIT:
//   - ctl_init=0; ctl_per=mode_l.
//   - pcnt counts rise events; tcnt counts cycles since ARM exit or since the last rise.
//  WAIT exit to RELEASE on the first of these (checked in priority order):
//   1) req[idx]=0;
//   2) single mode and pcnt reaches 1;
//   3) periodic mode and pcnt reaches NPULSE;
//   4) tcnt reaches TIMEOUT-1 with no rise, which sets the err flag.
//  Exits 1-3 leave err=0.
//  RELEASE (exactly 1 cycle):
//   - ctl_per=0, ctl_init=0, gnt=0.
//   - done[idx]=1 if req[idx] was still high at WAIT exit.
//   - err=1 if the timeout caused the exit.
//   - ptr=(idx+1) mod N; then go to IDLE.
//  Minimum idle gap: 1 IDLE cycle always separates two grants, so the controller sees per=0 between services.
//  Requests arriving while busy are held by the requester (level protocol) and are not queued internally.
//  A rise in the same cycle as a req drop: the req drop wins; the release has done=0.
//  Counter widths: ceil(log2(max+1)); counters are cleared on ARM entry and never wrap.
//  Single requester re-requesting: it is re-granted after one IDLE cycle.
//   - With other requests pending, the round-robin order gives the others priority first.
// TESTING
//  T1 reset:
//   - Stimulus: rst_n=0 mid-WAIT with req=4'b0010.
//   - Required: all outputs 0 in the same cycle; after release, first grant goes to req bit 1 with ptr=0.
//  T2 single:
//   - Stimulus: req=4'b0001, mode=0, a controller model pulses once 3 cycles after ARM.
//   - Required: ctl_init high for 8 cycles; done[0] strobe; busy for 8+3+1+1 cycles.
//  T3 periodic:
//   - Stimulus: req[2]=1, mode[2]=1, a pulse every 10 cycles.
//   - Required: ctl_per=1 until the 4th rise; then RELEASE with done[2]=1 and ctl_per=0.
//  T4 round-robin:
//   - Stimulus: req=4'b1111 held, all single.
//   - Required: grant order 0,1,2,3,0 with one IDLE cycle between grants.
//  T5 drop/timeout:
//   - Stimulus A: req[1] dropped during WAIT. Required: release, done=0, err=0.
//   - Stimulus B: no pulse for 256 cycles. Required: err=1 strobe and done strobe.
//  T6 simultaneous events:
//   - Stimulus: rise and req drop in the same cycle.
//   - Required: done=0, pcnt ignored; the next requester is granted after one IDLE cycle.

Source files
------------

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter that lends one shared pulse controller to N requesters,
// drives its init/per inputs, counts returned pulses and releases on completion, drop or timeout.
module pulse_arbiter #(
  parameter int N           = 4,
  parameter int INIT_CYCLES = 8,
  parameter int NPULSE      = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mode,
  input  logic         ctl_pulse,
  output logic         ctl_init,
  output logic         ctl_per,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic         err,
  output logic         busy
);

  localparam int IW = $clog2(N);
  localparam int AW = $clog2(INIT_CYCLES + 1);
  localparam int PW = $clog2(NPULSE + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_REL} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           mode_q, mode_d;
  logic [AW-1:0]  acnt_q, acnt_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           pulse_q;
  logic           init_q, init_d;
  logic           per_q, per_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   done_q, done_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic           rise_s;
  logic           found_s;
  logic           hit_s;
  logic [IW-1:0]  pick_s;
  logic [IW-1:0]  cand_s;
  logic [PW-1:0]  pcnt_n_s;

  assign rise_s = ctl_pulse & ~pulse_q;

  // Round-robin pick: first set request scanning from ptr upward, wrapping at N.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s  = IW'((int'(ptr_q) + k) % N);
      hit_s   = ~found_s & req[cand_s];
      pick_s  = hit_s ? cand_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Service sequencing and counters.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    acnt_d   = acnt_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    pcnt_n_s = pcnt_q + PW'(rise_s);
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_ARM;
          idx_d   = pick_s;
          mode_d  = mode[pick_s];
          acnt_d  = '0;
          pcnt_d  = '0;
          tcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (acnt_q == AW'(INIT_CYCLES - 1)) begin
          state_d = S_WAIT;
        end else begin
          acnt_d = acnt_q + AW'(1'b1);
        end
      end
      S_WAIT: begin
        // A dropped request outranks a pulse arriving in the same cycle.
        if (!req[idx_q]) begin
          state_d = S_REL;
        end else if (!mode_q && (pcnt_n_s >= PW'(1'b1))) begin
          state_d        = S_REL;
          done_d[idx_q]  = 1'b1;
        end else if (mode_q && (pcnt_n_s >= PW'(NPULSE))) begin
          state_d        = S_REL;
          done_d[idx_q]  = 1'b1;
        end else if (!rise_s && (tcnt_q == TW'(TIMEOUT - 1))) begin
          state_d        = S_REL;
          done_d[idx_q]  = 1'b1;
          err_d          = 1'b1;
        end else begin
          pcnt_d = pcnt_n_s;
          tcnt_d = rise_s ? '0 : tcnt_q + TW'(1'b1);
        end
      end
      S_REL: begin
        state_d = S_IDLE;
        ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1'b1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller-facing outputs decoded from the next state so they change with it.
  always_comb begin
    init_d = (state_d == S_ARM);
    busy_d = (state_d != S_IDLE);
    if ((state_d == S_ARM) || (state_d == S_WAIT)) begin
      gnt_d = N'(1'b1) << idx_d;
      per_d = mode_d;
    end else begin
      gnt_d = '0;
      per_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      acnt_q  <= '0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      pulse_q <= 1'b0;
      init_q  <= 1'b0;
      per_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      acnt_q  <= acnt_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      pulse_q <= ctl_pulse;
      init_q  <= init_d;
      per_q   <= per_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ctl_init = init_q;
  assign ctl_per  = per_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule
